// File: rtl/obstacle_guard_if.sv
// obstacle_guard_if: sample and command bundle of the obstacle guard.
//   distance   [5:0] range in cm from the ranging stage (0 = no echo)
//   dist_valid       one-cycle strobe, distance is new
//   avg_dist   [5:0] current 4-sample average in cm
//   avg_valid        one-cycle strobe when avg_dist updates
//   stop             1 = obstacle or unknown, halt the drive
//   fault            watchdog tripped
// master: sample producer / command consumer; slave: the guard itself.
interface obstacle_guard_if;
    logic [5:0] distance;
    logic       dist_valid;
    logic [5:0] avg_dist;
    logic       avg_valid;
    logic       stop;
    logic       fault;

    modport master (
        output distance, dist_valid,
        input  avg_dist, avg_valid, stop, fault
    );

    modport slave (
        input  distance, dist_valid,
        output avg_dist, avg_valid, stop, fault
    );
endinterface

// File: rtl/obstacle_guard.sv
// obstacle_guard: turns ultrasonic range samples into a debounced, hysteretic
// stop command (4-deep moving average, near/far thresholds, confirm counter).
// Fails safe: stop is 1 out of reset and until the averaging window is full.
// Optional feature macro: GUARD_WATCHDOG_EN (sample-timeout watchdog; without
// it fault is tied to 0 and a silent sensor holds the last state).
// Ports:
//   c1MHz  system clock
//   rst_n  asynchronous active-low reset
//   bus    obstacle_guard_if.slave (distance/dist_valid in,
//          avg_dist/avg_valid/stop/fault out)
module obstacle_guard #(
    parameter int unsigned NEAR_CM = 10,
    parameter int unsigned FAR_CM  = 15,
    parameter int unsigned CONFIRM = 2,
    parameter int unsigned TIMEOUT = 250000
) (
    input  logic            c1MHz,
    input  logic            rst_n,
    obstacle_guard_if.slave bus
);
    localparam logic [2:0] ST_INIT       = 3'd0;
    localparam logic [2:0] ST_CLEAR      = 3'd1;
    localparam logic [2:0] ST_NEAR_PEND  = 3'd2;
    localparam logic [2:0] ST_BLOCKED    = 3'd3;
    localparam logic [2:0] ST_CLEAR_PEND = 3'd4;

    localparam logic [5:0] NEAR_V = 6'(NEAR_CM);
    localparam logic [5:0] FAR_V  = 6'(FAR_CM);
    localparam logic [2:0] CONF_V = 3'(CONFIRM);

    if (FAR_CM <= NEAR_CM || FAR_CM > 63) begin : g_bad_thresholds
        $error("obstacle_guard: need NEAR_CM < FAR_CM <= 63");
    end
    if (CONFIRM < 1 || CONFIRM > 7) begin : g_bad_confirm
        $error("obstacle_guard: CONFIRM must be 1..7");
    end
    if (TIMEOUT < 1 || TIMEOUT > 262143) begin : g_bad_timeout
        $error("obstacle_guard: TIMEOUT must fit the 18-bit watchdog");
    end

    logic            accept, is_near, is_far;
    logic [3:0][5:0] win_q, win_d;
    logic [7:0]      sum_q, sum_d;
    logic [2:0]      fill_q, fill_d;
    logic            pend_q, pend_d;
    logic            avg_valid_q, avg_valid_d;
    logic [5:0]      avg_dist_q, avg_dist_d;
    logic [2:0]      state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            stop_q, stop_d;
`ifdef GUARD_WATCHDOG_EN
    localparam logic [17:0] WD_LIMIT = 18'(TIMEOUT);
    logic [17:0]     wd_q, wd_d;
    logic            fault_q, fault_d;
`endif

    always_comb begin
        accept = bus.dist_valid && (bus.distance != '0);

        // Stage 1: window, running sum and fill count.
        win_d  = win_q;
        sum_d  = sum_q;
        fill_d = fill_q;
        pend_d = 1'b0;
        if (accept) begin
            win_d  = {win_q[2:0], bus.distance};
            sum_d  = sum_q + {2'b00, bus.distance} - {2'b00, win_q[3]};
            fill_d = (fill_q == 3'd4) ? fill_q : fill_q + 3'd1;
            pend_d = (fill_d == 3'd4);
        end

        // Stage 2: publish the average one cycle after the window moved.
        avg_valid_d = pend_q;
        avg_dist_d  = pend_q ? sum_q[7:2] : avg_dist_q;

        // Stage 3: classify and run the confirmation FSM.
        is_near = (avg_dist_q <= NEAR_V);
        is_far  = (avg_dist_q >= FAR_V);
        state_d = state_q;
        cnt_d   = cnt_q;
        if (avg_valid_q) begin
            unique case (state_q)
                ST_INIT: state_d = is_far ? ST_CLEAR : ST_BLOCKED;
                ST_CLEAR, ST_NEAR_PEND: begin
                    if (is_near) begin
                        cnt_d = (state_q == ST_CLEAR) ? 3'd1 : cnt_q + 3'd1;
                        if (cnt_d >= CONF_V) begin
                            state_d = ST_BLOCKED;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_NEAR_PEND;
                        end
                    end else begin
                        state_d = ST_CLEAR;
                        cnt_d   = '0;
                    end
                end
                ST_BLOCKED, ST_CLEAR_PEND: begin
                    if (is_far) begin
                        cnt_d = (state_q == ST_BLOCKED) ? 3'd1 : cnt_q + 3'd1;
                        if (cnt_d >= CONF_V) begin
                            state_d = ST_CLEAR;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_CLEAR_PEND;
                        end
                    end else begin
                        state_d = ST_BLOCKED;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            endcase
        end

`ifdef GUARD_WATCHDOG_EN
        // A sample on the expiry edge wins; expiry overrides the FSM result
        // and forces a refill, leaving window/sum contents stale but unused.
        wd_d    = wd_q;
        fault_d = fault_q;
        if (accept) begin
            wd_d    = '0;
            fault_d = 1'b0;
        end else if (wd_q != WD_LIMIT) begin
            wd_d = wd_q + 18'd1;
            if (wd_d == WD_LIMIT) begin
                fault_d = 1'b1;
                state_d = ST_INIT;
                cnt_d   = '0;
                fill_d  = '0;
            end
        end
`endif

        stop_d = !((state_d == ST_CLEAR) || (state_d == ST_NEAR_PEND));
    end

    always_ff @(posedge c1MHz or negedge rst_n) begin
        if (!rst_n) begin
            win_q       <= '0;
            sum_q       <= '0;
            fill_q      <= '0;
            pend_q      <= 1'b0;
            avg_valid_q <= 1'b0;
            avg_dist_q  <= '0;
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            stop_q      <= 1'b1;
`ifdef GUARD_WATCHDOG_EN
            wd_q        <= '0;
            fault_q     <= 1'b0;
`endif
        end else begin
            win_q       <= win_d;
            sum_q       <= sum_d;
            fill_q      <= fill_d;
            pend_q      <= pend_d;
            avg_valid_q <= avg_valid_d;
            avg_dist_q  <= avg_dist_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stop_q      <= stop_d;
`ifdef GUARD_WATCHDOG_EN
            wd_q        <= wd_d;
            fault_q     <= fault_d;
`endif
        end
    end

    assign bus.avg_dist  = avg_dist_q;
    assign bus.avg_valid = avg_valid_q;
    assign bus.stop      = stop_q;
`ifdef GUARD_WATCHDOG_EN
    assign bus.fault     = fault_q;
`else
    assign bus.fault     = 1'b0;
`endif
endmodule

// File: tb/tb_obstacle_guard.sv
// tb_obstacle_guard: self-checking bench for obstacle_guard with a
// sample-level reference model (window as a queue, hysteresis as a
// confirmed mode plus a streak counter).
`timescale 1ns/1ps
module tb_obstacle_guard;
    localparam int NEAR = 10;
    localparam int FAR  = 15;
    localparam int CONF = 2;
    localparam int TMO  = 1000;

    logic c1MHz = 1'b0;
    logic rst_n = 1'b0;
    obstacle_guard_if bus();

    obstacle_guard #(.NEAR_CM(NEAR), .FAR_CM(FAR), .CONFIRM(CONF), .TIMEOUT(TMO)) dut (
        .c1MHz (c1MHz),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 c1MHz = ~c1MHz;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state. m_mode: 0 unknown, 1 clear, 2 blocked.
    int m_win[$];
    int m_fill, p_avg, m_avg, m_mode, m_run, m_wd;
    bit p_val, m_av, m_stop, m_fault;

    function automatic void model_reset();
        m_win = {0, 0, 0, 0};
        m_fill = 0; p_val = 0; p_avg = 0; m_av = 0; m_avg = 0;
        m_mode = 0; m_run = 0; m_stop = 1; m_fault = 0; m_wd = 0;
    endfunction

    function automatic void model_edge(input bit dv, input int d);
        bit acc;
        int s;
        acc = dv && (d != 0);
        if (m_av) begin
            if (m_mode == 0) m_mode = (m_avg >= FAR) ? 1 : 2;
            else if (m_mode == 1) begin
                if (m_avg <= NEAR) begin
                    m_run++;
                    if (m_run >= CONF) begin m_mode = 2; m_run = 0; end
                end else m_run = 0;
            end else begin
                if (m_avg >= FAR) begin
                    m_run++;
                    if (m_run >= CONF) begin m_mode = 1; m_run = 0; end
                end else m_run = 0;
            end
        end
        m_av = p_val;
        if (p_val) m_avg = p_avg;
        if (acc) begin
            m_win.push_back(d);
            void'(m_win.pop_front());
            if (m_fill < 4) m_fill++;
            s = 0;
            foreach (m_win[i]) s += m_win[i];
            p_val = (m_fill == 4);
            p_avg = s / 4;
        end else p_val = 0;
`ifdef GUARD_WATCHDOG_EN
        if (acc) begin
            m_wd = 0; m_fault = 0;
        end else if (m_wd < TMO) begin
            m_wd++;
            if (m_wd == TMO) begin m_fault = 1; m_mode = 0; m_run = 0; m_fill = 0; end
        end
`endif
        m_stop = (m_mode != 1);
    endfunction

    // One clock: drive inputs, take the edge, advance the model, sample #1 later.
    task automatic cycle(input bit dv, input int d);
        bus.dist_valid = dv;
        bus.distance   = d[5:0];
        @(posedge c1MHz);
        model_edge(dv, d);
        #1;
        bus.dist_valid = 1'b0;
        bus.distance   = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.dist_valid = 1'b0;
        bus.distance = '0;
        model_reset();
        repeat (2) @(posedge c1MHz);
        #1;
        n_cmp++; if (bus.stop !== 1'b1) begin n_bad++; $display("FAIL reset_stop got %0b exp 1", bus.stop); end
        n_cmp++; if (bus.avg_dist !== 6'd0) begin n_bad++; $display("FAIL reset_avg got %0d exp 0", bus.avg_dist); end
        n_cmp++; if (bus.avg_valid !== 1'b0) begin n_bad++; $display("FAIL reset_avg_valid got %0b exp 0", bus.avg_valid); end
        n_cmp++; if (bus.fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault got %0b exp 0", bus.fault); end
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        bit ev, es;
        for (int k = 1; k <= 4; k++) begin
            cycle(1'b1, 40);
            n_cmp++; if (bus.avg_valid !== 1'b0) begin n_bad++; $display("FAIL fill_e0_valid s%0d got %0b exp 0", k, bus.avg_valid); end
            for (int j = 0; j < 10; j++) begin
                cycle(1'b0, 0);
                ev = (k == 4 && j == 0);
                es = !(k == 4 && j >= 1);
                n_cmp++; if (bus.avg_valid !== ev) begin n_bad++; $display("FAIL fill_valid s%0d c%0d got %0b exp %0b", k, j, bus.avg_valid, ev); end
                n_cmp++; if (bus.stop !== es) begin n_bad++; $display("FAIL fill_stop s%0d c%0d got %0b exp %0b", k, j, bus.stop, es); end
                if (ev) begin
                    n_cmp++; if (bus.avg_dist !== 6'd40) begin n_bad++; $display("FAIL fill_avg got %0d exp 40", bus.avg_dist); end
                end
            end
        end
    endtask

    task automatic test_block();
        int exp_avg[5] = '{31, 22, 13, 5, 5};
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 5);
            n_cmp++; if (bus.stop !== 1'b0) begin n_bad++; $display("FAIL block_e0_stop s%0d got %0b exp 0", i, bus.stop); end
            cycle(1'b0, 0);
            n_cmp++; if (bus.avg_valid !== 1'b1) begin n_bad++; $display("FAIL block_valid s%0d got %0b exp 1", i, bus.avg_valid); end
            n_cmp++; if (bus.avg_dist !== 6'(exp_avg[i])) begin n_bad++; $display("FAIL block_avg s%0d got %0d exp %0d", i, bus.avg_dist, exp_avg[i]); end
            n_cmp++; if (bus.stop !== 1'b0) begin n_bad++; $display("FAIL block_e1_stop s%0d got %0b exp 0", i, bus.stop); end
            cycle(1'b0, 0);
            n_cmp++; if (bus.stop !== (i == 4)) begin n_bad++; $display("FAIL block_stop s%0d got %0b exp %0b", i, bus.stop, i == 4); end
            cycle(1'b0, 0);
        end
    endtask

    task automatic test_hysteresis();
        int smp[8]     = '{12, 12, 12, 12, 16, 16, 16, 16};
        int exp_avg[8] = '{6, 8, 10, 12, 13, 14, 15, 16};
        bit exp_stp[8] = '{1, 1, 1, 1, 1, 1, 1, 0};
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, smp[i]);
            cycle(1'b0, 0);
            n_cmp++; if (bus.avg_dist !== 6'(exp_avg[i])) begin n_bad++; $display("FAIL hyst_avg s%0d got %0d exp %0d", i, bus.avg_dist, exp_avg[i]); end
            cycle(1'b0, 0);
            n_cmp++; if (bus.stop !== exp_stp[i]) begin n_bad++; $display("FAIL hyst_stop s%0d got %0b exp %0b", i, bus.stop, exp_stp[i]); end
            cycle(1'b0, 0);
        end
    endtask

    task automatic test_zeros();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 0);
            cycle(1'b0, 0);
            n_cmp++; if (bus.avg_valid !== 1'b0) begin n_bad++; $display("FAIL zero_valid i%0d got %0b exp 0", i, bus.avg_valid); end
            n_cmp++; if (bus.avg_dist !== 6'd16) begin n_bad++; $display("FAIL zero_avg i%0d got %0d exp 16", i, bus.avg_dist); end
            n_cmp++; if (bus.stop !== 1'b0) begin n_bad++; $display("FAIL zero_stop i%0d got %0b exp 0", i, bus.stop); end
        end
    endtask

    task automatic test_random();
        int level, d, band;
        bit dv;
        level = 40;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                band = $urandom_range(0, 2);
                level = (band == 0) ? $urandom_range(1, 10) : (band == 1) ? $urandom_range(11, 14) : $urandom_range(15, 63);
            end
            dv = ($urandom_range(0, 3) != 0);
            d = level + $urandom_range(0, 4) - 2;
            if (d < 1) d = 1;
            if (d > 63) d = 63;
            if ($urandom_range(0, 9) == 0) d = 0;
            cycle(dv, d);
            n_cmp++; if (bus.avg_valid !== m_av) begin n_bad++; $display("FAIL rand_valid c%0d got %0b exp %0b", i, bus.avg_valid, m_av); end
            n_cmp++; if (bus.avg_dist !== 6'(m_avg)) begin n_bad++; $display("FAIL rand_avg c%0d got %0d exp %0d", i, bus.avg_dist, m_avg); end
            n_cmp++; if (bus.stop !== m_stop) begin n_bad++; $display("FAIL rand_stop c%0d got %0b exp %0b", i, bus.stop, m_stop); end
            n_cmp++; if (bus.fault !== m_fault) begin n_bad++; $display("FAIL rand_fault c%0d got %0b exp %0b", i, bus.fault, m_fault); end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) cycle(1'b1, 40);
        repeat (3) cycle(1'b0, 0);
        n_cmp++; if (bus.stop !== 1'b0) begin n_bad++; $display("FAIL b2b_stop got %0b exp 0", bus.stop); end
        n_cmp++; if (bus.avg_dist !== 6'd40) begin n_bad++; $display("FAIL b2b_avg got %0d exp 40", bus.avg_dist); end
    endtask

    task automatic test_reset_midrun();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 5);
            repeat (2) cycle(1'b0, 0);
        end
        n_cmp++; if (bus.stop !== 1'b0) begin n_bad++; $display("FAIL rmid_pend_stop got %0b exp 0", bus.stop); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.stop !== 1'b1) begin n_bad++; $display("FAIL rmid_stop got %0b exp 1", bus.stop); end
        n_cmp++; if (bus.avg_dist !== 6'd0) begin n_bad++; $display("FAIL rmid_avg got %0d exp 0", bus.avg_dist); end
        model_reset();
        @(posedge c1MHz);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 40);
            for (int j = 0; j < 3; j++) begin
                cycle(1'b0, 0);
                n_cmp++; if (bus.avg_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid s%0d got %0b exp 0", i, bus.avg_valid); end
                n_cmp++; if (bus.stop !== 1'b1) begin n_bad++; $display("FAIL rmid_post_stop s%0d got %0b exp 1", i, bus.stop); end
            end
        end
    endtask

`ifdef GUARD_WATCHDOG_EN
    task automatic test_watchdog();
        for (int i = 0; i < 4; i++) cycle(1'b1, 40);
        for (int n = 1; n <= TMO; n++) begin
            cycle(1'b0, 0);
            if (n == 3 || n == TMO - 1) begin
                n_cmp++; if (bus.fault !== 1'b0) begin n_bad++; $display("FAIL wd_early_fault n%0d got %0b exp 0", n, bus.fault); end
                n_cmp++; if (bus.stop !== 1'b0) begin n_bad++; $display("FAIL wd_early_stop n%0d got %0b exp 0", n, bus.stop); end
            end
        end
        n_cmp++; if (bus.fault !== 1'b1) begin n_bad++; $display("FAIL wd_fault got %0b exp 1", bus.fault); end
        n_cmp++; if (bus.stop !== 1'b1) begin n_bad++; $display("FAIL wd_stop got %0b exp 1", bus.stop); end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 40);
            n_cmp++; if (bus.fault !== 1'b0) begin n_bad++; $display("FAIL wd_clear s%0d got %0b exp 0", i, bus.fault); end
            cycle(1'b0, 0);
            n_cmp++; if (bus.stop !== 1'b1) begin n_bad++; $display("FAIL wd_e1_stop s%0d got %0b exp 1", i, bus.stop); end
            cycle(1'b0, 0);
            n_cmp++; if (bus.stop !== (i != 3)) begin n_bad++; $display("FAIL wd_refill_stop s%0d got %0b exp %0b", i, bus.stop, i != 3); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_block();
        test_hysteresis();
        test_zeros();
        test_random();
        test_back_to_back();
        test_reset_midrun();
`ifdef GUARD_WATCHDOG_EN
        test_watchdog();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
